// File: rtl/imem_loader.sv
// Program loader: assembles a big-endian byte stream into 32-bit words and writes them
// into instruction memory while holding the CPU. Optional checksum: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  localparam int         CW          = $clog2(DEPTH_WORDS + 1)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_start,
  input  logic          i_byte_valid,
  input  logic [7:0]    i_byte,
  input  logic          i_byte_last,
  output logic          o_byte_ready,
  output logic          o_imem_write,
  output logic [31:0]   o_imem_addr,
  output logic [31:0]   o_imem_data,
  output logic          o_cpu_hold,
  output logic          o_done,
  output logic          o_overflow,
  output logic [CW-1:0] o_word_count,
  output logic          o_csum_err
);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  state_t        state_q, state_d;
  logic [31:0]   buf_q, buf_d;
  logic [1:0]    bcnt_q, bcnt_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ready_q, ready_d;
  logic          write_q, write_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic          hold_q, hold_d;
  logic          done_q, done_d;
  logic          ovf_q, ovf_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]    sum_q, sum_d;
  logic [7:0]    sum_next;
  logic          bad_q, bad_d;
  logic          cerr_q, cerr_d;
`endif

  logic          accept;
  logic          fire;
  logic [31:0]   shifted;
  logic [31:0]   word;

  // Left-justify the n most recently shifted-in bytes, zero-filling the low bytes.
  function automatic logic [31:0] justify(input logic [31:0] w, input logic [2:0] n);
    case (n)
      3'd1:    justify = {w[7:0], 24'h0};
      3'd2:    justify = {w[15:0], 16'h0};
      3'd3:    justify = {w[23:0], 8'h0};
      default: justify = w;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    bcnt_d  = bcnt_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    write_d = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    hold_d  = hold_q;
    done_d  = done_q;
    ovf_d   = ovf_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d    = sum_q;
    bad_d    = bad_q;
    cerr_d   = cerr_q;
    sum_next = sum_q + i_byte;
`endif
    fire    = 1'b0;
    word    = 32'h0;
    shifted = {buf_q[23:0], i_byte};
    accept  = (state_q == RECV) && i_byte_valid && ready_q;

    case (state_q)
      IDLE, DONE: begin
        if (i_start) begin
          state_d = RECV;
          ready_d = 1'b1;
          hold_d  = 1'b1;
          done_d  = 1'b0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          bcnt_d  = 2'd0;
          last_d  = 1'b0;
          buf_d   = 32'h0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d   = 8'h0;
          bad_d   = 1'b0;
          cerr_d  = 1'b0;
`endif
        end
      end
      RECV: begin
        if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          if (i_byte_last) begin
            // Checksum byte carries no data: flush whatever is pending.
            last_d = 1'b1;
            bad_d  = (sum_next != 8'h00);
            if (bcnt_q == 2'd0) begin
              state_d = DONE;
              ready_d = 1'b0;
              hold_d  = 1'b0;
              done_d  = 1'b1;
              cerr_d  = (sum_next != 8'h00);
            end else begin
              fire = 1'b1;
              word = justify(buf_q, {1'b0, bcnt_q});
            end
          end else begin
            sum_d  = sum_next;
            buf_d  = shifted;
            bcnt_d = bcnt_q + 2'd1;
            if (bcnt_q == 2'd3) begin
              fire = 1'b1;
              word = shifted;
            end
          end
`else
          last_d = i_byte_last;
          buf_d  = shifted;
          bcnt_d = bcnt_q + 2'd1;
          if (i_byte_last || (bcnt_q == 2'd3)) begin
            fire = 1'b1;
            word = justify(shifted, {1'b0, bcnt_q} + 3'd1);
          end
`endif
        end
      end
      WRITE: begin
        if (last_q) begin
          state_d = DONE;
          hold_d  = 1'b0;
          done_d  = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          cerr_d  = bad_q;
`endif
        end else begin
          state_d = RECV;
          ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A completed word either overflows the target memory or is written out.
    if (fire) begin
      bcnt_d  = 2'd0;
      ready_d = 1'b0;
      if (cnt_q == CW'(DEPTH_WORDS)) begin
        state_d = DONE;
        hold_d  = 1'b0;
        done_d  = 1'b1;
        ovf_d   = 1'b1;
      end else begin
        state_d = WRITE;
        write_d = 1'b1;
        addr_d  = BASE_ADDR + (32'(cnt_q) << 2);
        data_d  = word;
        cnt_d   = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      buf_q   <= 32'h0;
      bcnt_q  <= 2'd0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= BASE_ADDR;
      data_q  <= 32'h0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q   <= 8'h0;
      bad_q   <= 1'b0;
      cerr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      bcnt_q  <= bcnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
      bad_q   <= bad_d;
      cerr_q  <= cerr_d;
`endif
    end
  end

  assign o_byte_ready = ready_q;
  assign o_imem_write = write_q;
  assign o_imem_addr  = addr_q;
  assign o_imem_data  = data_q;
  assign o_cpu_hold   = hold_q;
  assign o_done       = done_q;
  assign o_overflow   = ovf_q;
  assign o_word_count = cnt_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign o_csum_err   = cerr_q;
`else
  assign o_csum_err   = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued by the stimulus and
// popped by per-instance monitors whenever a write strobe appears.
module tb_imem_loader;

  logic       clk = 1'b0;
  logic       rst, start1, start2, valid, last;
  logic [7:0] bval;

  logic        rdy1, wr1, hold1, done1, ovf1, cerr1;
  logic [31:0] addr1, data1;
  logic [8:0]  cnt1;
  logic        rdy2, wr2, hold2, done2, ovf2, cerr2;
  logic [31:0] addr2, data2;
  logic [1:0]  cnt2;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;
  wr_t q1[$];
  wr_t q2[$];

  imem_loader dut (
    .i_clk(clk), .i_reset(rst), .i_start(start1), .i_byte_valid(valid),
    .i_byte(bval), .i_byte_last(last), .o_byte_ready(rdy1), .o_imem_write(wr1),
    .o_imem_addr(addr1), .o_imem_data(data1), .o_cpu_hold(hold1), .o_done(done1),
    .o_overflow(ovf1), .o_word_count(cnt1), .o_csum_err(cerr1)
  );

  imem_loader #(.DEPTH_WORDS(2)) dut2 (
    .i_clk(clk), .i_reset(rst), .i_start(start2), .i_byte_valid(valid),
    .i_byte(bval), .i_byte_last(last), .o_byte_ready(rdy2), .o_imem_write(wr2),
    .o_imem_addr(addr2), .o_imem_data(data2), .o_cpu_hold(hold2), .o_done(done2),
    .o_overflow(ovf2), .o_word_count(cnt2), .o_csum_err(cerr2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s", name);
  endtask

  logic prev1 = 1'b0;
  logic prev2 = 1'b0;

  always @(negedge clk) begin
    wr_t e;
    if (prev1) begin
      chk("dut_strobe_one_cycle", 32'(wr1), 32'd0);
      chk("dut_ready_after_write", 32'(rdy1 | done1), 32'd1);
    end
    if (wr1) begin
      chk("dut_ready_low_in_write", 32'(rdy1), 32'd0);
      if (q1.size() == 0) fail_now("dut_unexpected_write");
      else begin
        e = q1.pop_front();
        chk("dut_addr", addr1, e.a);
        chk("dut_data", data1, e.d);
      end
    end
    prev1 = wr1;
    if (prev2) chk("dut2_strobe_one_cycle", 32'(wr2), 32'd0);
    if (wr2) begin
      if (q2.size() == 0) fail_now("dut2_unexpected_write");
      else begin
        e = q2.pop_front();
        chk("dut2_addr", addr2, e.a);
        chk("dut2_data", data2, e.d);
      end
    end
    prev2 = wr2;
  end

  task automatic exp1(input logic [31:0] a, input logic [31:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    q1.push_back(e);
  endtask

  task automatic exp2(input logic [31:0] a, input logic [31:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    q2.push_back(e);
  endtask

  task automatic do_start(input bit sel);
    if (sel) start2 = 1'b1;
    else     start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic send(input logic [7:0] v, input logic l, input int gap, input bit sel);
    logic ok;
    int   n;
    if (gap > 0) begin
      repeat (gap) @(posedge clk);
      #1;
    end
    valid = 1'b1;
    bval  = v;
    last  = l;
    n     = 0;
    ok    = 1'b0;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = sel ? rdy2 : rdy1;
      @(posedge clk);
      n++;
    end
    if (!ok) fail_now("byte_accept_timeout");
    #1;
    valid = 1'b0;
    last  = 1'b0;
  endtask

  task automatic wait_done(input bit sel);
    int  n;
    logic d;
    n = 0;
    d = 1'b0;
    while (!d && n < 100) begin
      @(negedge clk);
      d = sel ? done2 : done1;
      n++;
    end
    if (!d) fail_now("done_timeout");
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] t2 [8];
    t2 = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
    rst = 1'b1; start1 = 1'b0; start2 = 1'b0; valid = 1'b0; last = 1'b0; bval = 8'h0;
    #12;
    chk("rst_ready", 32'(rdy1), 32'd0);
    chk("rst_write", 32'(wr1), 32'd0);
    chk("rst_addr", addr1, 32'h0);
    chk("rst_data", data1, 32'h0);
    chk("rst_hold", 32'(hold1), 32'd1);
    chk("rst_done", 32'(done1), 32'd0);
    chk("rst_ovf", 32'(ovf1), 32'd0);
    chk("rst_count", 32'(cnt1), 32'd0);
    chk("rst_csum", 32'(cerr1), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_ready", 32'(rdy1), 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    do_start(1'b0);
    exp1(32'h0, 32'h01020304);
    send(8'h01, 1'b0, 0, 1'b0); send(8'h02, 1'b0, 0, 1'b0);
    send(8'h03, 1'b0, 0, 1'b0); send(8'h04, 1'b0, 0, 1'b0);
    send(8'hF6, 1'b1, 0, 1'b0);
    wait_done(1'b0);
    chk("cs_ok_err", 32'(cerr1), 32'd0);
    chk("cs_ok_count", 32'(cnt1), 32'd1);

    do_start(1'b0);
    exp1(32'h0, 32'h01020304);
    send(8'h01, 1'b0, 0, 1'b0); send(8'h02, 1'b0, 0, 1'b0);
    send(8'h03, 1'b0, 0, 1'b0); send(8'h04, 1'b0, 0, 1'b0);
    send(8'h00, 1'b1, 0, 1'b0);
    wait_done(1'b0);
    chk("cs_bad_err", 32'(cerr1), 32'd1);

    do_start(1'b0);
    chk("cs_start_clears_err", 32'(cerr1), 32'd0);
    exp1(32'h0, 32'h01020000);
    send(8'h01, 1'b0, 0, 1'b0); send(8'h02, 1'b0, 0, 1'b0);
    send(8'hFD, 1'b1, 0, 1'b0);
    wait_done(1'b0);
    chk("cs_flush_err", 32'(cerr1), 32'd0);
    chk("cs_flush_count", 32'(cnt1), 32'd1);

    do_start(1'b0);
    send(8'h00, 1'b1, 0, 1'b0);
    wait_done(1'b0);
    chk("cs_bare_count", 32'(cnt1), 32'd0);
    chk("cs_bare_err", 32'(cerr1), 32'd0);
`else
    // Single word.
    do_start(1'b0);
    exp1(32'h0, 32'h20080005);
    send(8'h20, 1'b0, 0, 1'b0); send(8'h08, 1'b0, 0, 1'b0);
    send(8'h00, 1'b0, 0, 1'b0); send(8'h05, 1'b1, 0, 1'b0);
    wait_done(1'b0);
    chk("t1_done", 32'(done1), 32'd1);
    chk("t1_hold", 32'(hold1), 32'd0);
    chk("t1_count", 32'(cnt1), 32'd1);
    chk("t1_ready", 32'(rdy1), 32'd0);

    // Two words with valid gaps.
    do_start(1'b0);
    chk("t2_hold_on_start", 32'(hold1), 32'd1);
    chk("t2_done_cleared", 32'(done1), 32'd0);
    chk("t2_count_cleared", 32'(cnt1), 32'd0);
    exp1(32'h0, 32'hDEADBEEF);
    exp1(32'h4, 32'h01234567);
    for (int i = 0; i < 8; i++) send(t2[i], (i == 7), (i * 3) % 4, 1'b0);
    wait_done(1'b0);
    chk("t2_count", 32'(cnt1), 32'd2);

    // Partial trailing word, with a start pulse mid-load that must be ignored.
    do_start(1'b0);
    exp1(32'h0, 32'h11223344);
    exp1(32'h4, 32'hAABB0000);
    send(8'h11, 1'b0, 0, 1'b0); send(8'h22, 1'b0, 0, 1'b0);
    do_start(1'b0);
    send(8'h33, 1'b0, 0, 1'b0); send(8'h44, 1'b0, 0, 1'b0);
    send(8'hAA, 1'b0, 1, 1'b0); send(8'hBB, 1'b1, 0, 1'b0);
    wait_done(1'b0);
    chk("t3_count", 32'(cnt1), 32'd2);

    // Single-byte stream.
    do_start(1'b0);
    exp1(32'h0, 32'h5A000000);
    send(8'h5A, 1'b1, 0, 1'b0);
    wait_done(1'b0);
    chk("t3b_count", 32'(cnt1), 32'd1);

    // Overflow on a 2-word memory.
    do_start(1'b1);
    exp2(32'h0, 32'h00010203);
    exp2(32'h4, 32'h04050607);
    for (int i = 0; i < 12; i++) send(8'(i), (i == 11), 0, 1'b1);
    wait_done(1'b1);
    chk("t4_overflow", 32'(ovf2), 32'd1);
    chk("t4_done", 32'(done2), 32'd1);
    chk("t4_count", 32'(cnt2), 32'd2);
    chk("t4_ready", 32'(rdy2), 32'd0);
    chk("t4_q2_empty", 32'(q2.size()), 32'd0);

    // Reset mid-load.
    do_start(1'b0);
    send(8'h01, 1'b0, 0, 1'b0); send(8'h02, 1'b0, 0, 1'b0);
    rst = 1'b1;
    #2;
    chk("t5_hold", 32'(hold1), 32'd1);
    chk("t5_count", 32'(cnt1), 32'd0);
    chk("t5_ready", 32'(rdy1), 32'd0);
    chk("t5_addr", addr1, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t5_idle_hold", 32'(hold1), 32'd1);
    do_start(1'b0);
    exp1(32'h0, 32'hCAFEBABE);
    send(8'hCA, 1'b0, 0, 1'b0); send(8'hFE, 1'b0, 0, 1'b0);
    send(8'hBA, 1'b0, 0, 1'b0); send(8'hBE, 1'b1, 0, 1'b0);
    wait_done(1'b0);
    chk("t5_reload_count", 32'(cnt1), 32'd1);
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("q1_empty", 32'(q1.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
